// File: rtl/gaussian_conv3x3.sv
// Streaming 3x3 Gaussian blur stage, kernel [1 2 1; 2 4 2; 1 2 1] / 16.
// Three lock-step registers under one stall enable, plus a per-frame output count.
module gaussian_conv3x3 #(
  parameter int ROUND = 1,
  parameter int CNT_W = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [71:0]      i_win_data,
  input  logic             i_win_valid,
  input  logic             i_win_last,
  output logic             o_win_ready,
  output logic [7:0]       o_pix_data,
  output logic             o_pix_valid,
  output logic             o_pix_last,
  input  logic             i_pix_ready,
  output logic [CNT_W-1:0] o_pix_count,
  output logic             o_frame_done
);

  // Middle row is stored halved (p3 + 2*p4 + p5) so all row sums fit 10 bits.
  typedef struct packed {
    logic       v;
    logic       l;
    logic [9:0] r0;
    logic [9:0] r1h;
    logic [9:0] r2;
  } s1_t;

  typedef struct packed {
    logic        v;
    logic        l;
    logic [11:0] sum;
  } s2_t;

  localparam logic [11:0] RND = (ROUND != 0) ? 12'd8 : 12'd0;

  function automatic logic [9:0] tap3(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic       en;
  logic       hs;
  logic [7:0] px [9];
  s1_t        s1;
  s2_t        s2;

  for (genvar k = 0; k < 9; k++) begin : g_px
    assign px[k] = i_win_data[8*k +: 8];
  end

  assign en          = ~o_pix_valid | i_pix_ready;
  assign o_win_ready = en;
  assign hs          = o_pix_valid & i_pix_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1          <= '0;
      s2          <= '0;
      o_pix_valid <= 1'b0;
      o_pix_last  <= 1'b0;
      o_pix_data  <= '0;
    end else if (en) begin
      s1.v        <= i_win_valid;
      s1.l        <= i_win_valid & i_win_last;
      s1.r0       <= tap3(px[0], px[1], px[2]);
      s1.r1h      <= tap3(px[3], px[4], px[5]);
      s1.r2       <= tap3(px[6], px[7], px[8]);
      s2.v        <= s1.v;
      s2.l        <= s1.l;
      s2.sum      <= {2'b00, s1.r0} + {1'b0, s1.r1h, 1'b0}
                   + {2'b00, s1.r2};
      o_pix_valid <= s2.v;
      o_pix_last  <= s2.l;
      o_pix_data  <= 8'((s2.sum + RND) >> 4);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pix_count  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= hs & o_pix_last;
      if (hs) begin
        if (o_pix_last) begin
          o_pix_count <= '0;
        end else begin
          o_pix_count <= o_pix_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gaussian_conv3x3.sv
// Randomised bench for gaussian_conv3x3: queue scoreboard against a
// weighted-sum reference, plus directed latency, stall, frame and reset cases.
module tb_gaussian_conv3x3;
  localparam int CNT_W = 19;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [71:0]      i_win_data = '0;
  logic             i_win_valid = 1'b0;
  logic             i_win_last = 1'b0;
  logic             i_pix_ready = 1'b0;
  logic             o_win_ready, o_win_ready0;
  logic [7:0]       o_pix_data, o_pix_data0;
  logic             o_pix_valid, o_pix_valid0;
  logic             o_pix_last, o_pix_last0;
  logic [CNT_W-1:0] o_pix_count, o_pix_count0;
  logic             o_frame_done, o_frame_done0;

  int total = 0;
  int bad = 0;
  int n_out = 0;

  typedef struct {
    logic [7:0] d1;
    logic [7:0] d0;
    logic       last;
  } exp_t;
  exp_t q[$];

  always #5 i_clk = ~i_clk;

  gaussian_conv3x3 #(.ROUND(1), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_win_data(i_win_data), .i_win_valid(i_win_valid),
    .i_win_last(i_win_last), .o_win_ready(o_win_ready),
    .o_pix_data(o_pix_data), .o_pix_valid(o_pix_valid),
    .o_pix_last(o_pix_last), .i_pix_ready(i_pix_ready),
    .o_pix_count(o_pix_count), .o_frame_done(o_frame_done)
  );

  gaussian_conv3x3 #(.ROUND(0), .CNT_W(CNT_W)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_win_data(i_win_data), .i_win_valid(i_win_valid),
    .i_win_last(i_win_last), .o_win_ready(o_win_ready0),
    .o_pix_data(o_pix_data0), .o_pix_valid(o_pix_valid0),
    .o_pix_last(o_pix_last0), .i_pix_ready(i_pix_ready),
    .o_pix_count(o_pix_count0), .o_frame_done(o_frame_done0)
  );

  function automatic logic [7:0] gauss(input logic [71:0] w, input bit rnd);
    int sum = 0;
    int wt;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) wt = 4;
      else if (k % 2 == 1) wt = 2;
      else wt = 1;
      sum += wt * int'(w[8*k +: 8]);
    end
    if (rnd) sum += 8;
    return 8'(sum / 16);
  endfunction

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  initial begin : monitor
    logic [CNT_W-1:0] exp_cnt;
    bit               exp_fd;
    bit               prev_stall;
    bit               ohs;
    logic             lst;
    logic [7:0]       hd1;
    logic             hl;
    exp_t             e;
    exp_cnt = '0;
    exp_fd = 0;
    prev_stall = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst !== 1'b0) begin
        q.delete();
        exp_cnt = '0;
        exp_fd = 0;
        prev_stall = 0;
      end else begin
        total++;
        if (o_pix_count !== exp_cnt) begin
          bad++;
          $display("FAIL mon_count t=%0t got=%0d want=%0d", $time, o_pix_count, exp_cnt);
        end
        total++;
        if (o_frame_done !== exp_fd) begin
          bad++;
          $display("FAIL mon_frame_done t=%0t got=%b want=%b", $time, o_frame_done, exp_fd);
        end
        total++;
        if (o_win_ready !== (!o_pix_valid || i_pix_ready)) begin
          bad++;
          $display("FAIL mon_win_ready t=%0t got=%b valid=%b pr=%b", $time, o_win_ready, o_pix_valid, i_pix_ready);
        end
        if (prev_stall) begin
          total++;
          if (o_pix_valid !== 1'b1 || o_pix_data !== hd1 || o_pix_last !== hl) begin
            bad++;
            $display("FAIL mon_hold t=%0t got=%b/%h/%b want=1/%h/%b", $time, o_pix_valid, o_pix_data, o_pix_last, hd1, hl);
          end
        end
        ohs = (o_pix_valid === 1'b1) && (i_pix_ready === 1'b1);
        lst = o_pix_last;
        if (ohs) begin
          n_out++;
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL mon_unexpected t=%0t got=%h want=none", $time, o_pix_data);
          end else begin
            e = q.pop_front();
            lst = e.last;
            if (o_pix_data !== e.d1 || o_pix_data0 !== e.d0 || o_pix_last !== e.last) begin
              bad++;
              $display("FAIL mon_data t=%0t got=%h/%h/%b want=%h/%h/%b", $time, o_pix_data, o_pix_data0, o_pix_last, e.d1, e.d0, e.last);
            end
          end
        end
        exp_fd = ohs && (lst === 1'b1);
        if (ohs) exp_cnt = (lst === 1'b1) ? '0 : exp_cnt + 1'b1;
        if (i_win_valid === 1'b1 && o_win_ready === 1'b1) begin
          e.d1 = gauss(i_win_data, 1);
          e.d0 = gauss(i_win_data, 0);
          e.last = i_win_last;
          q.push_back(e);
        end
        prev_stall = (o_pix_valid === 1'b1) && (i_pix_ready === 1'b0);
        hd1 = o_pix_data;
        hl = o_pix_last;
      end
    end
  end

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    i_win_valid = 1'b0;
    i_win_last = 1'b0;
    i_pix_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic send_one(input logic [71:0] w, input logic last,
                          output logic [7:0] d1, output logic [7:0] d0,
                          output logic l, output int lat);
    @(posedge i_clk); #1;
    i_win_data = w;
    i_win_valid = 1'b1;
    i_win_last = last;
    i_pix_ready = 1'b1;
    @(posedge i_clk); #1;
    i_win_valid = 1'b0;
    i_win_last = 1'b0;
    lat = 1;
    while (o_pix_valid !== 1'b1 && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    d1 = o_pix_data;
    d0 = o_pix_data0;
    l = o_pix_last;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_pix_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #2;
    total++;
    if (o_win_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_win_ready); end
    total++;
    if (o_pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_pix_valid); end
    total++;
    if (o_pix_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", o_pix_last); end
    total++;
    if (o_pix_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", o_pix_data); end
    total++;
    if (o_pix_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", o_pix_count); end
    total++;
    if (o_frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_frame_done); end
  endtask

  task automatic test_single();
    logic [7:0] d1, d0;
    logic l;
    int lat;
    send_one({9{8'h80}}, 1'b0, d1, d0, l, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL single_latency got=%0d want=3", lat); end
    total++;
    if (d1 !== 8'h80) begin bad++; $display("FAIL single_data got=%h want=80", d1); end
    total++;
    if (d0 !== 8'h80) begin bad++; $display("FAIL single_data_trunc got=%h want=80", d0); end
    total++;
    if (l !== 1'b0) begin bad++; $display("FAIL single_last got=%b want=0", l); end
    total++;
    if (o_pix_count !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", o_pix_count); end
  endtask

  task automatic test_values();
    logic [7:0] d1, d0;
    logic l;
    int lat;
    logic [71:0] w;
    send_one({9{8'hFF}}, 1'b0, d1, d0, l, lat);
    total++;
    if (d1 !== 8'hFF || d0 !== 8'hFF) begin bad++; $display("FAIL allff got=%h/%h want=ff/ff", d1, d0); end
    w = '0;
    w[39:32] = 8'hFF;
    send_one(w, 1'b0, d1, d0, l, lat);
    total++;
    if (d1 !== 8'h40) begin bad++; $display("FAIL centre_round got=%h want=40", d1); end
    total++;
    if (d0 !== 8'h3F) begin bad++; $display("FAIL centre_trunc got=%h want=3f", d0); end
    w = '0;
    w[7:0] = 8'hFF;
    send_one(w, 1'b0, d1, d0, l, lat);
    total++;
    if (d1 !== 8'h10 || d0 !== 8'h0F) begin bad++; $display("FAIL corner got=%h/%h want=10/0f", d1, d0); end
    w = '0;
    w[15:8] = 8'hFF;
    send_one(w, 1'b0, d1, d0, l, lat);
    total++;
    if (d1 !== 8'h20 || d0 !== 8'h1F) begin bad++; $display("FAIL edge got=%h/%h want=20/1f", d1, d0); end
  endtask

  task automatic test_stall();
    int sent = 0;
    int n0 = n_out;
    logic [71:0] beats [20];
    logic [7:0] held = '0;
    for (int i = 0; i < 20; i++) beats[i] = rnd72();
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk); #1;
      i_pix_ready = !(c >= 8 && c < 13);
      i_win_valid = (sent < 20);
      i_win_data = (sent < 20) ? beats[sent] : '0;
      i_win_last = 1'b0;
      #3;
      if (c == 8) held = o_pix_data;
      if (c > 8 && c < 13) begin
        total++;
        if (o_win_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=0", c, o_win_ready); end
        total++;
        if (o_pix_valid !== 1'b1 || o_pix_data !== held) begin
          bad++;
          $display("FAIL stall_hold c=%0d got=%b/%h want=1/%h", c, o_pix_valid, o_pix_data, held);
        end
      end
      if (i_win_valid && o_win_ready) sent++;
    end
    i_win_valid = 1'b0;
    total++;
    if (n_out - n0 !== 20) begin bad++; $display("FAIL stall_outputs got=%0d want=20", n_out - n0); end
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL stall_pending got=%0d want=0", q.size()); end
  endtask

  task automatic test_frame();
    int idx = 0;
    int fdn = 0;
    bit pend = 0;
    int want [4] = '{1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge i_clk); #1;
      i_win_valid = (c < 4);
      i_win_last = (c == 3);
      i_win_data = rnd72();
      i_pix_ready = 1'b1;
      #3;
      if (o_frame_done === 1'b1) fdn++;
      if (pend) begin
        pend = 0;
        if (idx <= 4) begin
          total++;
          if (o_pix_count !== want[idx-1]) begin
            bad++;
            $display("FAIL frame_count n=%0d got=%0d want=%0d", idx, o_pix_count, want[idx-1]);
          end
          total++;
          if (o_frame_done !== (idx == 4)) begin
            bad++;
            $display("FAIL frame_done n=%0d got=%b want=%b", idx, o_frame_done, (idx == 4));
          end
        end
      end
      if (o_pix_valid === 1'b1 && i_pix_ready) begin
        total++;
        if (o_pix_last !== (idx == 3)) begin
          bad++;
          $display("FAIL frame_last n=%0d got=%b want=%b", idx, o_pix_last, (idx == 3));
        end
        idx++;
        pend = 1;
      end
    end
    i_win_valid = 1'b0;
    i_win_last = 1'b0;
    total++;
    if (idx !== 4) begin bad++; $display("FAIL frame_outputs got=%0d want=4", idx); end
    total++;
    if (fdn !== 1) begin bad++; $display("FAIL frame_done_pulses got=%0d want=1", fdn); end
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    int n0 = n_out;
    logic [CNT_W-1:0] cnt_in = '0;
    while (sent < 1000 && cyc < 20000) begin
      @(posedge i_clk); #1;
      cyc++;
      i_win_valid = ($urandom_range(9) < 7);
      i_win_data = rnd72();
      i_win_last = ($urandom_range(15) == 0);
      i_pix_ready = ($urandom_range(9) < 7);
      #3;
      if (i_win_valid && o_win_ready) begin
        sent++;
        cnt_in = i_win_last ? '0 : cnt_in + 1'b1;
      end
    end
    @(posedge i_clk); #1;
    i_win_valid = 1'b0;
    i_win_last = 1'b0;
    i_pix_ready = 1'b1;
    repeat (10) @(posedge i_clk);
    #3;
    total++;
    if (sent !== 1000) begin bad++; $display("FAIL rand_sent got=%0d want=1000", sent); end
    total++;
    if (n_out - n0 !== 1000) begin bad++; $display("FAIL rand_outputs got=%0d want=1000", n_out - n0); end
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL rand_pending got=%0d want=0", q.size()); end
    total++;
    if (o_pix_count !== cnt_in) begin bad++; $display("FAIL rand_count got=%0d want=%0d", o_pix_count, cnt_in); end
  endtask

  task automatic test_reset_inflight();
    logic [7:0] d1, d0;
    logic l;
    int lat;
    logic [71:0] w;
    @(posedge i_clk); #1;
    i_pix_ready = 1'b1;
    i_win_valid = 1'b1;
    i_win_data = rnd72();
    @(posedge i_clk); #1;
    i_win_data = rnd72();
    @(posedge i_clk); #1;
    i_win_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    total++;
    if (o_pix_valid !== 1'b0) begin bad++; $display("FAIL inflight_valid got=%b want=0", o_pix_valid); end
    total++;
    if (o_pix_count !== '0) begin bad++; $display("FAIL inflight_count got=%0d want=0", o_pix_count); end
    i_rst = 1'b0;
    w = rnd72();
    send_one(w, 1'b0, d1, d0, l, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL inflight_latency got=%0d want=3", lat); end
    total++;
    if (d1 !== gauss(w, 1) || d0 !== gauss(w, 0)) begin
      bad++;
      $display("FAIL inflight_data got=%h/%h want=%h/%h", d1, d0, gauss(w, 1), gauss(w, 0));
    end
    total++;
    if (o_pix_count !== 1) begin bad++; $display("FAIL inflight_count_after got=%0d want=1", o_pix_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_values();
    test_stall();
    test_frame();
    test_random();
    test_reset_inflight();
    repeat (3) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
